// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter feeding the shared UART TX FIFO.
// One grantee at a time; the grant is released at burst end.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         last,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         ack,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wdata,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST);

  typedef enum logic {
    IDLE,
    XFER
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic [DATA_W-1:0]  wbyte [NUM_REQ];
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic               sel_req;
  logic               accept;
  logic               eob;

  function automatic logic [ID_W-1:0] wrap_add(
    input logic [ID_W-1:0] a,
    input int              b
  );
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign wbyte[i] = wdata[i*DATA_W +: DATA_W];
  end

  // Scan downwards so the offset closest to rr_ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(rr_ptr_q, k)]) begin
        win_vld = 1'b1;
        win_id  = wrap_add(rr_ptr_q, k);
      end
    end
  end

  assign busy    = (state_q == XFER);
  assign sel_req = req[grant_id_q];
  assign accept  = busy & sel_req & ~fifo_full;
  assign eob     = busy & (~sel_req |
                   (accept & (last[grant_id_q] |
                   (burst_cnt_q == CNT_W'(MAX_BURST - 1)))));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = XFER;
          grant_d     = NUM_REQ'(1) << win_id;
          grant_id_d  = win_id;
          burst_cnt_d = '0;
        end
      end
      XFER: begin
        if (accept) burst_cnt_d = burst_cnt_q + 1'b1;
        if (eob) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_add(grant_id_q, 1);
        end
      end
    endcase
  end

  always_comb begin
    fifo_wr_en = accept;
    ack        = '0;
    fifo_wdata = '0;
    if (accept) ack[grant_id_q] = 1'b1;
    if (busy) fifo_wdata = wbyte[grant_id_q];
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;

endmodule
